// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and sizes for the register-file write arbiter
package regfile_wb_arbiter_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREG     = 32;
  localparam int DEF_MAX_WAIT = 4;
  localparam int REG_AW       = 5;

  // Arbiter FSM: WB normally wins; LLU_FORCE gives the held LLU result one guaranteed slot
  typedef enum logic {
    WB_PRIO   = 1'b0,
    LLU_FORCE = 1'b1
  } arb_state_t;

  // Which source owns the write port in the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_HB   = 2'd2
  } gnt_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rtl/regfile_wb_arbiter_scoreboard.sv - pending LLU write bitmap and issue hazard compare
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREG = DEF_NREG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic [NREG-1:0]   pending,
  output logic              hazard
);

  logic [NREG-1:0] pending_nxt;

  // Clear first, then set, so a dispatch landing on the retiring edge keeps the bit; x0 never pends
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (set_en) pending_nxt[set_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Bitmap register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  // Any issue-stage operand or destination that names an outstanding LLU write stalls issue
  always_comb begin
    hazard = ((chk_rs1 != '0) && pending[chk_rs1])
           | ((chk_rs2 != '0) && pending[chk_rs2])
           | ((chk_rd  != '0) && pending[chk_rd]);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between WB and the long-latency unit
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_ready,
  input  logic              llu_valid,
  input  logic [REG_AW-1:0] llu_rd,
  input  logic [XLEN-1:0]   llu_data,
  output logic              llu_ready,
  input  logic              disp_valid,
  input  logic [REG_AW-1:0] disp_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rd,
  output logic              hazard,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREG-1:0]   pending
);

  localparam int                AGE_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [AGE_W-1:0]  AGE_LAST = AGE_W'(MAX_WAIT - 1);
  localparam logic [AGE_W-1:0]  AGE_SAT  = '1;

  arb_state_t        state;
  logic [AGE_W-1:0]  age;
  logic              hb_v;
  logic [REG_AW-1:0] hb_rd;
  logic [XLEN-1:0]   hb_data;
  logic              rf_from_hb;

  gnt_src_t          gnt;
  logic [REG_AW-1:0] gnt_rd;
  logic [XLEN-1:0]   gnt_data;

  assign wb_ready  = (state == WB_PRIO);
  assign llu_ready = !hb_v;

  // Pick the write-port owner: forced slot for the held result, otherwise WB first, then HB
  always_comb begin
    gnt      = GNT_NONE;
    gnt_rd   = wb_rd;
    gnt_data = wb_data;
    if (state == LLU_FORCE) begin
      gnt      = GNT_HB;
      gnt_rd   = hb_rd;
      gnt_data = hb_data;
    end else if (wb_valid) begin
      gnt = GNT_WB;
    end else if (hb_v) begin
      gnt      = GNT_HB;
      gnt_rd   = hb_rd;
      gnt_data = hb_data;
    end
  end

  // FSM, starvation age, hold buffer and the registered write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WB_PRIO;
      age        <= '0;
      hb_v       <= 1'b0;
      hb_rd      <= '0;
      hb_data    <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      rf_from_hb <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      rf_from_hb <= 1'b0;

      // llu_ready is low whenever HB holds data, so capture never collides with an HB grant
      if (llu_valid && !hb_v) begin
        hb_v    <= 1'b1;
        hb_rd   <= llu_rd;
        hb_data <= llu_data;
      end

      if (gnt != GNT_NONE) begin
        rf_we    <= (gnt_rd != '0);
        rf_rd    <= gnt_rd;
        rf_wdata <= gnt_data;
      end

      case (state)
        WB_PRIO: begin
          if (gnt == GNT_WB) begin
            if (hb_v) begin
              if (age == AGE_LAST) state <= LLU_FORCE;
              if (age != AGE_SAT)  age   <= age + 1'b1;
            end
          end else if (gnt == GNT_HB) begin
            hb_v       <= 1'b0;
            age        <= '0;
            rf_from_hb <= 1'b1;
          end
        end
        LLU_FORCE: begin
          hb_v       <= 1'b0;
          age        <= '0;
          rf_from_hb <= 1'b1;
          state      <= WB_PRIO;
        end
        default: state <= WB_PRIO;
      endcase
    end
  end

  regfile_wb_arbiter_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk     (clk),
    .reset_n (reset_n),
    .set_en  (disp_valid),
    .set_rd  (disp_rd),
    .clr_en  (rf_we && rf_from_hb),
    .clr_rd  (rf_rd),
    .chk_rs1 (chk_rs1),
    .chk_rs2 (chk_rs2),
    .chk_rd  (chk_rd),
    .pending (pending),
    .hazard  (hazard)
  );

endmodule
